// File: rtl/instr_cycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_cycle_sequencer                                         |
// | Desc     : Sequence counter (SC) and timing generator for the basic-     |
// |            computer CPU. Produces one-hot T, latches opcode decode D and |
// |            the I bit, and runs fetch/decode/indirect/execute/halt.       |
// | Config   : define INTERRUPT_CYCLE_EN to enable the R flip-flop and the   |
// |            RT0..RT2 interrupt cycle; otherwise R is held at 0.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_cycle_sequencer #(
  parameter int SC_BITS  = 3,
  parameter int MAX_STEP = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             ir,
  input  logic                    mem_busy,
  input  logic                    start,
  input  logic                    ien,
  input  logic                    fgi,
  input  logic                    fgo,
  output logic [2**SC_BITS-1:0]   T,
  output logic [7:0]              D,
  output logic                    i_bit,
  output logic [SC_BITS-1:0]      sc_count,
  output logic                    sc_clr,
  output logic                    running,
  output logic                    seq_err,
  output logic                    r_cycle,
  output logic                    ien_clr
);

  localparam int T_W = 2**SC_BITS;

  localparam logic [SC_BITS-1:0] c_t2  = SC_BITS'(2);
  localparam logic [SC_BITS-1:0] c_t3  = SC_BITS'(3);
  localparam logic [SC_BITS-1:0] c_t4  = SC_BITS'(4);
  localparam logic [SC_BITS-1:0] c_t5  = SC_BITS'(5);
  localparam logic [SC_BITS-1:0] c_t6  = SC_BITS'(6);
  localparam logic [SC_BITS-1:0] c_max = SC_BITS'(MAX_STEP);

  logic [SC_BITS-1:0] sc_q, sc_d;
  logic [7:0]         d_q, d_d;
  logic               i_bit_q, i_bit_d;
  logic               running_q, running_d;
  logic               seq_err_q, seq_err_d;
  logic               r_q, r_d;

  logic [T_W-1:0]     t_onehot;
  logic               exec_done;
  logic               int_done;
  logic               halt_now;
  logic               r_cycle_w;

  // ir[11:1] carry address/operand bits the sequencer never looks at; the
  // interrupt inputs only matter when the interrupt cycle is built in.
  logic unused_inputs;
  assign unused_inputs = ^{ir[11:1], ien, fgi, fgo};

  // State register: SC, latched decode, I bit, S flag, error flag, R flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_q      <= '0;
      d_q       <= '0;
      i_bit_q   <= 1'b0;
      running_q <= 1'b1;
      seq_err_q <= 1'b0;
      r_q       <= 1'b0;
    end else begin
      sc_q      <= sc_d;
      d_q       <= d_d;
      i_bit_q   <= i_bit_d;
      running_q <= running_d;
      seq_err_q <= seq_err_d;
      r_q       <= r_d;
    end
  end

  // Output decode: timing, end-of-instruction detection, halt and interrupt strobes
  always_comb begin
    t_onehot         = '0;
    t_onehot[sc_q]   = 1'b1;
    T                = running_q ? t_onehot : '0;

    // R only becomes set after T2, so R=1 while SC<=2 means the interrupt
    // cycle is in progress rather than a normal fetch.
    r_cycle_w = r_q && running_q && (sc_q <= c_t2);

    // Last execution step per opcode group; D is valid from T3 onward.
    exec_done = ((d_q[0] | d_q[1] | d_q[2] | d_q[5]) && (sc_q == c_t5)) ||
                ((d_q[3] | d_q[4])                   && (sc_q == c_t4)) ||
                (d_q[6]                              && (sc_q == c_t6)) ||
                (d_q[7]                              && (sc_q == c_t3));
    int_done  = r_cycle_w && (sc_q == c_t2);

    sc_clr    = running_q && (r_cycle_w ? int_done : exec_done);
    halt_now  = running_q && !r_cycle_w && d_q[7] && !i_bit_q && ir[0] &&
                (sc_q == c_t3);

    D         = d_q;
    i_bit     = i_bit_q;
    sc_count  = sc_q;
    running   = running_q;
    seq_err   = seq_err_q;
    r_cycle   = r_cycle_w;
    ien_clr   = int_done;
  end

  // Next-state: SC priority is halted, out-of-range guard, clear, stall, increment
  always_comb begin
    sc_d      = sc_q;
    d_d       = d_q;
    i_bit_d   = i_bit_q;
    running_d = running_q;
    seq_err_d = seq_err_q;
    r_d       = 1'b0;

    if (!running_q) begin
      sc_d = '0;
      if (start) begin
        running_d = 1'b1;
      end
    end else begin
      if (sc_q > c_max) begin
        // An illegal step can only come from an upset; recover to T0 and flag it.
        seq_err_d = 1'b1;
        sc_d      = '0;
      end else if (sc_clr) begin
        sc_d = '0;
      end else if (!mem_busy) begin
        sc_d = sc_q + SC_BITS'(1);
      end

      if (halt_now) begin
        running_d = 1'b0;
      end

      // Decode step: capture opcode and addressing mode for the execute steps.
      if (!r_cycle_w && (sc_q == c_t2)) begin
        d_d     = 8'h01 << ir[14:12];
        i_bit_d = ir[15];
      end
    end

`ifdef INTERRUPT_CYCLE_EN
    r_d = r_q;
    if (int_done) begin
      r_d = 1'b0;
    end else if (running_q && (sc_q > c_t2) && ien && (fgi || fgo)) begin
      r_d = 1'b1;
    end
`else
    r_d = 1'b0;
`endif
  end

endmodule
`default_nettype wire
